imm_share_arbiter: RTL and testbench
====================================

IMM_SHARE_ARBITER -- requirements
Module: imm_share_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, meaning the number of requesters sharing the immediate generator; only value 2 is supported.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-004 The block SHALL have port flush, input, 1, which discards the held response and blocks acceptance that cycle.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1 each, meaning the requester presents an instruction.
REQ-006 The block SHALL have ports req0_inst / req1_inst, input, 32 each, meaning the instruction word to decode.
REQ-007 The block SHALL have ports req0_ready / req1_ready, output, 1 each, meaning the request is accepted this cycle.
REQ-008 The block SHALL have port resp_valid, output, 1, meaning resp_imm and resp_id are valid.
REQ-009 The block SHALL have port resp_id, output, 1, meaning the index of the requester that owns the response.
REQ-010 The block SHALL have port resp_imm, output, 32, meaning the registered immediate for the accepted instruction.
REQ-011 The block SHALL have port resp_ready, input, 1, meaning the consumer takes the response this cycle.

Function
REQ-012 Transfer rules: acceptance = valid && ready on a request port; consumption = resp_valid && resp_ready.
REQ-013 Requesters SHALL hold valid and inst stable until accepted; ready may depend combinationally on valid, but valid SHALL NOT depend on ready.
REQ-014 FSM states SHALL be IDLE (no held response) and HOLD (response held).
REQ-015 The block SHALL be able to accept (can_accept) when: state==IDLE, or (state==HOLD && resp_ready), and flush==0.
REQ-016 At most one reqN_ready SHALL be high per cycle, and only when can_accept and that reqN_valid are high.
REQ-017 Arbitration with a single valid request SHALL grant that requester.
REQ-018 Arbitration with both requests valid SHALL grant the requester opposite last_grant (round-robin).
REQ-019 last_grant SHALL update to the granted index on acceptance only.
REQ-020 On acceptance, the next cycle SHALL have resp_valid=1, resp_id=granted index, and resp_imm=immediate of the granted inst (one-cycle latency); the state SHALL be HOLD.
REQ-021 In HOLD without resp_ready, resp_valid/resp_id/resp_imm SHALL remain stable.
REQ-022 In HOLD, resp_ready with no acceptance SHALL move the state to IDLE with resp_valid=0 the next cycle.
REQ-023 In HOLD, resp_ready with a simultaneous acceptance SHALL keep the state in HOLD and load the new response (throughput one per cycle).
REQ-024 flush=1 SHALL force state IDLE and resp_valid=0 next cycle, drop any held response, and hold both readies low; last_grant SHALL be unchanged.
REQ-025 Simultaneous flush and resp_ready: flush SHALL win and no acceptance occurs.
REQ-026 Immediate formation SHALL be identical to the codebase immediate generator for the accepted inst, with no further width change.

Reset
REQ-027 While reset=1, the state SHALL be IDLE, with resp_valid=0, resp_id=0, resp_imm=0 and last_grant=1 (requester 0 wins first contention).
REQ-028 Readies SHALL be 0 while reset=1.
REQ-029 Reset asserted mid-HOLD SHALL drop the response with no consumption; reset takes priority over flush.

Structure
REQ-030 Shared package imm_arb_pkg SHALL hold the FSM state enum (IDLE, HOLD) and the typedef req_id_t (1 bit).
REQ-031 The block SHALL instantiate exactly one sub-module, imm_Gen, fed by a mux selecting the granted inst; its output is registered into resp_imm.
REQ-032 The block SHALL have no other storage beyond state, last_grant, resp_id and resp_imm.

Verification
REQ-033 Single request: req0_valid=1, req0_inst=32'h00500093, resp_ready=1 -> req0_ready same cycle; next cycle resp_valid=1, resp_id=0, resp_imm=32'h00000005.
REQ-034 Contention after reset: both valid, req0=32'h00500093, req1=32'hFFC12083, resp_ready=1 -> cycle1 resp (id0, 0x00000005); cycle2 resp (id1, 0xFFFFFFFC); readies alternate.
REQ-035 Backpressure: resp_ready=0 for 3 cycles after acceptance -> resp held stable; no readies high; on resp_ready=1 with req1 valid, new accept that same cycle.
REQ-036 Flush: in HOLD with resp_ready=1 and req0_valid=1, assert flush -> req0_ready=0; next cycle resp_valid=0, state IDLE.
REQ-037 Reset mid-HOLD: reset=1 for one cycle -> resp_valid=0, resp_imm=0; next contention grants requester 0.
REQ-038 Throughput: both requesters continuously valid, resp_ready=1 for 10 cycles -> 10 responses, ids alternating 0,1,0,..., no bubbles.

Source files
------------

// File: rtl/imm_arb_pkg.sv
// Shared definitions for the two-requester immediate-generator arbiter.
// Holds the response FSM states, the requester index type, RV32I opcode
// constants used by the immediate generator, and the round-robin helper.
package imm_arb_pkg;

    // Response holding register: empty or holding a response
    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Index of a requester (only two requesters exist)
    typedef logic req_id_t;

    // After reset requester 1 is treated as the last winner,
    // so requester 0 wins the first contention
    localparam req_id_t RESET_LAST_GRANT = 1'b1;

    // RV32I major opcodes that carry an immediate
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;

    // Round-robin pick: a lone requester always wins, on contention the
    // requester that did not win last time gets the grant
    function automatic req_id_t rr_pick(input logic v0, input logic v1,
                                        input req_id_t last);
        req_id_t pick;
        if (v0 && v1) begin
            pick = ~last;
        end else if (v1) begin
            pick = 1'b1;
        end else begin
            pick = 1'b0;
        end
        return pick;
    endfunction

endpackage

// File: rtl/imm_share_arbiter_imm_gen.sv
// RV32I immediate generator. Produces the sign-extended 32-bit immediate
// for the instruction format implied by the opcode; formats without an
// immediate (R-type, system, unknown) yield zero.
module imm_Gen
    import imm_arb_pkg::*;
(
    input  logic [31:0] inst,
    output logic [31:0] imm
);

    // Reassemble the immediate fields according to the instruction format
    always_comb begin
        imm = 32'h0000_0000;
        case (inst[6:0])
            OPC_LOAD, OPC_OP_IMM, OPC_JALR: begin
                imm = {{20{inst[31]}}, inst[31:20]};
            end
            OPC_STORE: begin
                imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
            end
            OPC_BRANCH: begin
                imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25],
                       inst[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                imm = {inst[31:12], 12'h000};
            end
            OPC_JAL: begin
                imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20],
                       inst[30:21], 1'b0};
            end
            default: begin
                imm = 32'h0000_0000;
            end
        endcase
    end

endmodule

// File: rtl/imm_share_arbiter.sv
// Two requesters share one immediate generator. A round-robin arbiter picks
// one instruction per cycle, the generator decodes it, and the result is
// registered as a single-entry response that the consumer drains with
// resp_ready. A drain and a new acceptance may happen in the same cycle,
// giving one response per cycle. flush drops the held response.
module imm_share_arbiter
    import imm_arb_pkg::*;
#(
    parameter int N_REQ = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        flush,
    input  logic        req0_valid,
    input  logic [31:0] req0_inst,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic [31:0] req1_inst,
    output logic        req1_ready,
    output logic        resp_valid,
    output logic        resp_id,
    output logic [31:0] resp_imm,
    input  logic        resp_ready
);

    state_t           state_q, state_d;
    req_id_t          last_grant_q, last_grant_d;
    req_id_t          resp_id_q, resp_id_d;
    logic [31:0]      resp_imm_q, resp_imm_d;

    req_id_t          grant;
    logic             can_accept;
    logic             accept;
    logic [N_REQ-1:0] ready_vec;
    logic [31:0]      sel_inst;
    logic [31:0]      gen_imm;

    // A new request fits when the holding register is empty or is being
    // drained this cycle; flush and reset close the window
    always_comb begin
        can_accept = !reset && !flush && ((state_q == IDLE) || resp_ready);
    end

    // Round-robin grant and the one-hot ready it produces
    always_comb begin
        grant     = rr_pick(req0_valid, req1_valid, last_grant_q);
        ready_vec = '0;
        if (can_accept) begin
            ready_vec[0] = req0_valid && (grant == 1'b0);
            ready_vec[1] = req1_valid && (grant == 1'b1);
        end
    end

    assign req0_ready = ready_vec[0];
    assign req1_ready = ready_vec[1];
    assign accept     = |ready_vec;

    // Steer the granted instruction into the shared generator
    always_comb begin
        sel_inst = (grant == 1'b1) ? req1_inst : req0_inst;
    end

    imm_Gen u_imm_gen (
        .inst (sel_inst),
        .imm  (gen_imm)
    );

    // Next response and arbitration history; acceptance outranks the
    // drain so a drain-plus-accept cycle keeps the register full
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        resp_id_d    = resp_id_q;
        resp_imm_d   = resp_imm_q;
        if (accept) begin
            state_d      = HOLD;
            last_grant_d = grant;
            resp_id_d    = grant;
            resp_imm_d   = gen_imm;
        end else if (flush) begin
            state_d = IDLE;
        end else if ((state_q == HOLD) && resp_ready) begin
            state_d = IDLE;
        end
    end

    // Register the response FSM, payload and grant history
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= RESET_LAST_GRANT;
            resp_id_q    <= 1'b0;
            resp_imm_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            resp_id_q    <= resp_id_d;
            resp_imm_q   <= resp_imm_d;
        end
    end

    assign resp_valid = (state_q == HOLD);
    assign resp_id    = resp_id_q;
    assign resp_imm   = resp_imm_q;

endmodule

// File: tb/tb_imm_share_arbiter.sv
// Self-checking bench for imm_share_arbiter: directed scenarios with
// hand-derived expectations plus a randomized run against a
// transaction-level model of the arbiter and an independent immediate model.
module tb_imm_share_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        flush;
    logic        req0_valid, req1_valid;
    logic [31:0] req0_inst, req1_inst;
    logic        req0_ready, req1_ready;
    logic        resp_valid;
    logic        resp_id;
    logic [31:0] resp_imm;
    logic        resp_ready;

    int checks = 0;
    int fails  = 0;

    localparam logic [31:0] ADDI5  = 32'h0050_0093;
    localparam logic [31:0] LDNEG4 = 32'hFFC1_2083;

    always #5 clk = ~clk;

    imm_share_arbiter #(.N_REQ(2)) dut (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush),
        .req0_valid (req0_valid),
        .req0_inst  (req0_inst),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_inst  (req1_inst),
        .req1_ready (req1_ready),
        .resp_valid (resp_valid),
        .resp_id    (resp_id),
        .resp_imm   (resp_imm),
        .resp_ready (resp_ready)
    );

    // Immediate value computed from the RV32I field definitions using
    // arithmetic shifts and masks
    function automatic logic [31:0] ref_imm(input logic [31:0] inst);
        logic signed [31:0] s;
        logic signed [31:0] t;
        logic [31:0] r;
        s = inst;
        r = 32'h0;
        case (inst[6:0])
            7'h03, 7'h13, 7'h67: begin
                t = s >>> 20;
                r = t;
            end
            7'h23: begin
                t = s >>> 25;
                r = (32'(t) << 5) | 32'(inst[11:7]);
            end
            7'h63: begin
                t = s >>> 31;
                r = (32'(t) << 12) | (32'(inst[7]) << 11)
                  | (32'(inst[30:25]) << 5) | (32'(inst[11:8]) << 1);
            end
            7'h37, 7'h17: r = inst & 32'hFFFF_F000;
            7'h6F: begin
                t = s >>> 31;
                r = (32'(t) << 20) | (inst & 32'h000F_F000)
                  | (32'(inst[20]) << 11) | (32'(inst[30:21]) << 1);
            end
            default: r = 32'h0;
        endcase
        return r;
    endfunction

    function automatic logic [31:0] rand_inst();
        logic [6:0] ops [9];
        logic [31:0] w;
        ops = '{7'h03, 7'h13, 7'h67, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F, 7'h33};
        w = $urandom();
        w[6:0] = ops[$urandom_range(8)];
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        flush = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        flush = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_inst = ADDI5;
        req1_inst = LDNEG4;
        resp_ready = 1'b1;
        tick();
        tick();
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL reset_readies actual=%b required=00", {req1_ready, req0_ready});
        end
        checks++;
        if ({resp_valid, resp_id, resp_imm} !== 34'h0) begin
            fails++;
            $display("[TB] FAIL reset_resp actual v=%b id=%b imm=%h required 0/0/0", resp_valid, resp_id, resp_imm);
        end
        reset = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req0_valid = 1'b1;
        req0_inst = ADDI5;
        resp_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL single_ready actual=%b required=01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if ({resp_valid, resp_id, resp_imm} !== {1'b1, 1'b0, 32'h5}) begin
            fails++;
            $display("[TB] FAIL single_resp actual v=%b id=%b imm=%h required 1/0/00000005", resp_valid, resp_id, resp_imm);
        end
        tick();
        checks++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL single_drain actual=%b required=0", resp_valid);
        end
    endtask

    task automatic test_contention();
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_inst = ADDI5;
        req1_inst = LDNEG4;
        resp_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL contention_ready0 actual=%b required=01", {req1_ready, req0_ready});
        end
        tick();
        checks++;
        if ({resp_valid, resp_id, resp_imm} !== {1'b1, 1'b0, 32'h5}) begin
            fails++;
            $display("[TB] FAIL contention_resp0 actual v=%b id=%b imm=%h required 1/0/00000005", resp_valid, resp_id, resp_imm);
        end
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL contention_ready1 actual=%b required=10", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        checks++;
        if ({resp_valid, resp_id, resp_imm} !== {1'b1, 1'b1, 32'hFFFF_FFFC}) begin
            fails++;
            $display("[TB] FAIL contention_resp1 actual v=%b id=%b imm=%h required 1/1/fffffffc", resp_valid, resp_id, resp_imm);
        end
        tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        req0_valid = 1'b1;
        req0_inst = ADDI5;
        resp_ready = 1'b0;
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b1;
        req1_inst = LDNEG4;
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++;
            if ({resp_valid, resp_id, resp_imm} !== {1'b1, 1'b0, 32'h5} ||
                {req1_ready, req0_ready} !== 2'b00) begin
                fails++;
                $display("[TB] FAIL backpressure_hold cycle=%0d actual v=%b id=%b imm=%h rdy=%b required 1/0/00000005 rdy=00",
                         i, resp_valid, resp_id, resp_imm, {req1_ready, req0_ready});
            end
            tick();
        end
        resp_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b10) begin
            fails++;
            $display("[TB] FAIL backpressure_accept actual=%b required=10", {req1_ready, req0_ready});
        end
        tick();
        req1_valid = 1'b0;
        resp_ready = 1'b0;
        checks++;
        if ({resp_valid, resp_id, resp_imm} !== {1'b1, 1'b1, 32'hFFFF_FFFC}) begin
            fails++;
            $display("[TB] FAIL backpressure_resp actual v=%b id=%b imm=%h required 1/1/fffffffc", resp_valid, resp_id, resp_imm);
        end
    endtask

    // Entered from the held response left by test_backpressure
    task automatic test_flush();
        resp_ready = 1'b1;
        req0_valid = 1'b1;
        req0_inst = ADDI5;
        flush = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL flush_ready actual=%b required=00", {req1_ready, req0_ready});
        end
        tick();
        flush = 1'b0;
        checks++;
        if (resp_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL flush_resp_valid actual=%b required=0", resp_valid);
        end
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL flush_idle_accept actual=%b required=01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_hold();
        do_reset();
        req0_valid = 1'b1;
        req0_inst = ADDI5;
        req1_inst = LDNEG4;
        tick();
        req0_valid = 1'b0;
        reset = 1'b1;
        flush = 1'b1;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        resp_ready = 1'b1;
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b00) begin
            fails++;
            $display("[TB] FAIL midhold_reset_ready actual=%b required=00", {req1_ready, req0_ready});
        end
        tick();
        reset = 1'b0;
        flush = 1'b0;
        checks++;
        if ({resp_valid, resp_imm} !== 33'h0) begin
            fails++;
            $display("[TB] FAIL midhold_reset_resp actual v=%b imm=%h required 0/00000000", resp_valid, resp_imm);
        end
        #1;
        checks++;
        if ({req1_ready, req0_ready} !== 2'b01) begin
            fails++;
            $display("[TB] FAIL midhold_regrant actual=%b required=01", {req1_ready, req0_ready});
        end
        tick();
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        do_reset();
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        req0_inst = ADDI5;
        req1_inst = LDNEG4;
        resp_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            checks++;
            if ({req1_ready, req0_ready} !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
                fails++;
                $display("[TB] FAIL throughput_ready cycle=%0d actual=%b", i, {req1_ready, req0_ready});
            end
            tick();
            checks++;
            if ({resp_valid, resp_id, resp_imm} !==
                {1'b1, 1'(i % 2), (i % 2 == 0) ? 32'h5 : 32'hFFFF_FFFC}) begin
                fails++;
                $display("[TB] FAIL throughput_resp cycle=%0d actual v=%b id=%b imm=%h", i, resp_valid, resp_id, resp_imm);
            end
        end
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        tick();
    endtask

    // Random traffic against a transaction model: one response slot, a
    // remembered last winner, requesters that wait until served
    task automatic test_random();
        logic        m_full;
        logic        m_id;
        logic [31:0] m_imm;
        logic        m_last;
        logic        open, g, e0, e1;
        do_reset();
        m_full = 1'b0;
        m_id = 1'b0;
        m_imm = 32'h0;
        m_last = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!req0_valid && $urandom_range(9) < 6) begin
                req0_valid = 1'b1;
                req0_inst = rand_inst();
            end
            if (!req1_valid && $urandom_range(9) < 6) begin
                req1_valid = 1'b1;
                req1_inst = rand_inst();
            end
            flush = ($urandom_range(15) == 0);
            resp_ready = ($urandom_range(3) != 0);
            #1;
            open = !flush && (!m_full || resp_ready);
            g = (req0_valid && req1_valid) ? !m_last : req1_valid;
            e0 = open && req0_valid && !g;
            e1 = open && req1_valid && g;
            checks++;
            if ({req1_ready, req0_ready} !== {e1, e0}) begin
                fails++;
                $display("[TB] FAIL random_ready cycle=%0d actual=%b required=%b", c, {req1_ready, req0_ready}, {e1, e0});
            end
            checks++;
            if (resp_valid !== m_full || (m_full && {resp_id, resp_imm} !== {m_id, m_imm})) begin
                fails++;
                $display("[TB] FAIL random_resp cycle=%0d actual v=%b id=%b imm=%h required v=%b id=%b imm=%h",
                         c, resp_valid, resp_id, resp_imm, m_full, m_id, m_imm);
            end
            tick();
            if (e0 || e1) begin
                m_full = 1'b1;
                m_id = g;
                m_imm = ref_imm(g ? req1_inst : req0_inst);
                m_last = g;
                if (g) req1_valid = 1'b0;
                else   req0_valid = 1'b0;
            end else if (flush || resp_ready) begin
                m_full = 1'b0;
            end
        end
        flush = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
    endtask

    initial begin
        reset = 1'b1;
        flush = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        req0_inst = 32'h0;
        req1_inst = 32'h0;
        resp_ready = 1'b0;
        #1;
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_flush();
        test_reset_mid_hold();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
